// File: rtl/vga_timing_gen_pkg.sv
// Shared raster timing defaults and the coordinate type used by renderers.
package vga_timing_pkg;

  // 640x480@60 defaults; top-level parameters take these unless overridden.
  localparam int unsigned H_ACTIVE_DEFAULT = 640;
  localparam int unsigned H_FP_DEFAULT     = 16;
  localparam int unsigned H_SYNC_DEFAULT   = 96;
  localparam int unsigned H_BP_DEFAULT     = 48;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam int unsigned V_FP_DEFAULT     = 10;
  localparam int unsigned V_SYNC_DEFAULT   = 2;
  localparam int unsigned V_BP_DEFAULT     = 33;

  localparam int unsigned H_TOTAL_DEFAULT =
    H_ACTIVE_DEFAULT + H_FP_DEFAULT + H_SYNC_DEFAULT + H_BP_DEFAULT;
  localparam int unsigned V_TOTAL_DEFAULT =
    V_ACTIVE_DEFAULT + V_FP_DEFAULT + V_SYNC_DEFAULT + V_BP_DEFAULT;

  // Largest total that a 10-bit coordinate can count through.
  localparam int unsigned COORD_LIMIT = 1024;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster position and sync bundle driven by vga_timing_gen.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t     DrawX;
  coord_t     DrawY;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, hs, vs, blank, frame_start, frame_count
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 while enabled and flags the wrap.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL     = H_TOTAL_DEFAULT,
  parameter int unsigned RESET_VAL = TOTAL - 1
) (
  input  logic   vga_clk,
  input  logic   reset_n,
  input  logic   en,
  output coord_t count,
  output coord_t next_count,
  output logic   wrap
);

  localparam coord_t LAST = coord_t'(TOTAL - 1);
  localparam coord_t INIT = coord_t'(RESET_VAL);

  // Next value is exposed so the top can decode outputs for the pixel the count is about to show.
  always_comb begin
    wrap       = en && (count == LAST);
    next_count = count;
    if (wrap) begin
      next_count = '0;
    end else if (en) begin
      next_count = count + coord_t'(1);
    end
  end

  // Position register; reset parks on the last position so the first edge lands on 0.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= INIT;
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: scan position, blank, negative syncs, frame pulse and counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEFAULT,
  parameter int unsigned H_FP     = H_FP_DEFAULT,
  parameter int unsigned H_SYNC   = H_SYNC_DEFAULT,
  parameter int unsigned H_BP     = H_BP_DEFAULT,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEFAULT,
  parameter int unsigned V_FP     = V_FP_DEFAULT,
  parameter int unsigned V_SYNC   = V_SYNC_DEFAULT,
  parameter int unsigned V_BP     = V_BP_DEFAULT
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_totals_too_large
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
  end

  coord_t     h_count, h_next;
  coord_t     v_count, v_next;
  logic       h_wrap, v_wrap;
  logic       blank_d, hs_d, vs_d, fs_d;
  logic       blank_q, hs_q, vs_q, fs_q;
  logic [7:0] frame_count_q;

  vga_axis_counter #(
    .TOTAL     (H_TOTAL),
    .RESET_VAL (H_TOTAL - 1)
  ) u_h_counter (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .en         (1'b1),
    .count      (h_count),
    .next_count (h_next),
    .wrap       (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL     (V_TOTAL),
    .RESET_VAL (V_TOTAL - 1)
  ) u_v_counter (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .en         (h_wrap),
    .count      (v_count),
    .next_count (v_next),
    .wrap       (v_wrap)
  );

  // Decode from the next position so registered outputs line up with DrawX/DrawY.
  always_comb begin
    int unsigned hx;
    int unsigned vy;
    hx      = {22'd0, h_next};
    vy      = {22'd0, v_next};
    blank_d = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    hs_d    = !((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC));
    vs_d    = !((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC));
    // Both axes wrapping together means the next pixel is (0,0).
    fs_d    = h_wrap && v_wrap;
  end

  // Output registers and frame counter; reset matches the parked last-pixel position.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q       <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      fs_q          <= 1'b0;
      frame_count_q <= '1;
    end else begin
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      if (fs_d) begin
        frame_count_q <= frame_count_q + 8'd1;
      end
    end
  end

  assign vga.DrawX       = h_count;
  assign vga.DrawY       = v_count;
  assign vga.blank       = blank_q;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = frame_count_q;

endmodule
